// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises one read or write frame at a time toward a PHY
// and hands read data back on a valid/ready handshake.
module mdio_master #(
    parameter int MDC_HALF_PERIOD = 25,
    parameter bit PREAMBLE_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mdio_wdata,
    input  logic [1:0]  mdio_op,
    input  logic [4:0]  mdio_reg_adr,
    input  logic [4:0]  mdio_phy_adr,
    input  logic        mdio_valid,
    output logic        mdio_ready,
    output logic        mdio_busy,
    output logic [15:0] mdio_rdata,
    output logic        mdio_rdata_valid,
    input  logic        mdio_rdata_ready,
    output logic        mdc_o,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t
);

    localparam int             HCW       = $clog2(MDC_HALF_PERIOD);
    localparam logic [HCW-1:0] HALF_LAST = HCW'(MDC_HALF_PERIOD - 1);
    localparam logic [5:0]     FIRST_BIT = PREAMBLE_EN ? 6'd0 : 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] halfCnt_q, halfCnt_d;
    logic           mdcHigh_q, mdcHigh_d;
    logic [5:0]     bitCnt_q, bitCnt_d;
    logic [1:0]     op_q, op_d;
    logic [4:0]     phyAdr_q, phyAdr_d;
    logic [4:0]     regAdr_q, regAdr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    shift_q, shift_d;
    logic [15:0]    rdata_q, rdata_d;

    logic           isRead;
    logic           halfEnd;
    logic           inFrame;
    logic           released;
    logic [31:0]    frameBits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            halfCnt_q <= '0;
            mdcHigh_q <= 1'b0;
            bitCnt_q  <= '0;
            op_q      <= '0;
            phyAdr_q  <= '0;
            regAdr_q  <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            halfCnt_q <= halfCnt_d;
            mdcHigh_q <= mdcHigh_d;
            bitCnt_q  <= bitCnt_d;
            op_q      <= op_d;
            phyAdr_q  <= phyAdr_d;
            regAdr_q  <= regAdr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
        end
    end

    assign isRead  = (op_q == 2'b10);
    assign halfEnd = (halfCnt_q == HALF_LAST);

    always_comb begin
        state_d   = state_q;
        halfCnt_d = halfCnt_q;
        mdcHigh_d = mdcHigh_q;
        bitCnt_d  = bitCnt_q;
        op_d      = op_q;
        phyAdr_d  = phyAdr_q;
        regAdr_d  = regAdr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (mdio_valid) begin
                    op_d     = mdio_op;
                    phyAdr_d = mdio_phy_adr;
                    regAdr_d = mdio_reg_adr;
                    wdata_d  = mdio_wdata;
                    // Opcodes 00/11 are swallowed here without ever leaving IDLE.
                    if (mdio_op == 2'b01 || mdio_op == 2'b10) begin
                        state_d   = FRAME;
                        halfCnt_d = '0;
                        mdcHigh_d = 1'b0;
                        bitCnt_d  = FIRST_BIT;
                    end
                end
            end
            FRAME: begin
                if (!halfEnd) begin
                    halfCnt_d = halfCnt_q + HCW'(1);
                end else begin
                    halfCnt_d = '0;
                    mdcHigh_d = ~mdcHigh_q;
                    if (!mdcHigh_q) begin
                        // Read data is captured just before the MDC rising edge.
                        if (isRead && bitCnt_q[5] && bitCnt_q[4]) begin
                            shift_d = {shift_q[14:0], mdio_i};
                        end
                    end else if (bitCnt_q == 6'd63) begin
                        mdcHigh_d = 1'b0;
                        if (isRead) begin
                            rdata_d = shift_q;
                            state_d = RESP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 6'd1;
                    end
                end
            end
            RESP: begin
                if (mdio_rdata_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bits 32..63 of the frame after the preamble; bit b lives at index 63-b (= ~b[4:0]).
    assign frameBits = {2'b01, op_q, phyAdr_q, regAdr_q,
                        isRead ? 2'b11 : 2'b10,
                        isRead ? 16'hFFFF : wdata_q};

    assign inFrame  = (state_q == FRAME);
    assign released = isRead && (bitCnt_q >= 6'd46);

    always_comb begin
        mdc_o  = inFrame & mdcHigh_q;
        mdio_t = !inFrame || released;
        mdio_o = 1'b1;
        if (inFrame && !released && bitCnt_q[5]) begin
            mdio_o = frameBits[~bitCnt_q[4:0]];
        end
    end

    assign mdio_ready       = (state_q == IDLE);
    assign mdio_busy        = (state_q != IDLE);
    assign mdio_rdata_valid = (state_q == RESP);
    assign mdio_rdata       = rdata_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: a table of read/write frames checked bit by bit at each MDC
// rise, plus hand sequences for response stall, invalid opcodes, mid-frame reset and no preamble.
module tb_mdio_master;

    localparam int HP = 2;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regAdr;
        logic [15:0] wdata;
        logic [15:0] phyData;
        logic [15:0] expRdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wdata = '0;
    logic [1:0]  op = '0;
    logic [4:0]  regAdr = '0;
    logic [4:0]  phyAdr = '0;
    logic        cmdValid = 1'b0;
    logic        useNp = 1'b0;
    logic        rdataReady = 1'b0;
    logic        mdioI = 1'b1;

    logic        validA, readyA, busyA, rdataValidA, mdcA, mdioOA, mdioTA;
    logic        validB, readyB, busyB, rdataValidB, mdcB, mdioOB, mdioTB;
    logic [15:0] rdataA, rdataB;

    logic        obsReady, obsBusy, obsValid, obsMdc, obsMdioO, obsMdioT;
    logic [15:0] obsRdata;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign validA = cmdValid & ~useNp;
    assign validB = cmdValid & useNp;

    assign obsReady = useNp ? readyB : readyA;
    assign obsBusy  = useNp ? busyB : busyA;
    assign obsValid = useNp ? rdataValidB : rdataValidA;
    assign obsMdc   = useNp ? mdcB : mdcA;
    assign obsMdioO = useNp ? mdioOB : mdioOA;
    assign obsMdioT = useNp ? mdioTB : mdioTA;
    assign obsRdata = useNp ? rdataB : rdataA;

    mdio_master #(.MDC_HALF_PERIOD(HP), .PREAMBLE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .mdio_wdata(wdata), .mdio_op(op),
        .mdio_reg_adr(regAdr), .mdio_phy_adr(phyAdr), .mdio_valid(validA),
        .mdio_ready(readyA), .mdio_busy(busyA), .mdio_rdata(rdataA),
        .mdio_rdata_valid(rdataValidA), .mdio_rdata_ready(rdataReady),
        .mdc_o(mdcA), .mdio_i(mdioI), .mdio_o(mdioOA), .mdio_t(mdioTA)
    );

    mdio_master #(.MDC_HALF_PERIOD(HP), .PREAMBLE_EN(1'b0)) dutNp (
        .clk(clk), .rst(rst), .mdio_wdata(wdata), .mdio_op(op),
        .mdio_reg_adr(regAdr), .mdio_phy_adr(phyAdr), .mdio_valid(validB),
        .mdio_ready(readyB), .mdio_busy(busyB), .mdio_rdata(rdataB),
        .mdio_rdata_valid(rdataValidB), .mdio_rdata_ready(rdataReady),
        .mdc_o(mdcB), .mdio_i(mdioI), .mdio_o(mdioOB), .mdio_t(mdioTB)
    );

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Value the PHY model puts on MDIO during bit b: TA bit 47 driven low, then the data MSB first.
    function automatic logic phyBit(input int b, input logic [15:0] data);
        if (b == 47) return 1'b0;
        if (b >= 48 && b <= 63) return data[63-b];
        return 1'b1;
    endfunction

    // Presents one command for a single cycle; called at a sample point while the DUT is idle.
    task automatic applyStimulus(input logic [1:0] cOp, input logic [4:0] cPhy,
                                 input logic [4:0] cReg, input logic [15:0] cData);
        op       = cOp;
        phyAdr   = cPhy;
        regAdr   = cReg;
        wdata    = cData;
        cmdValid = 1'b1;
        @(posedge clk); #1;
        cmdValid = 1'b0;
    endtask

    task automatic runFrame(input vec_t v, input int firstBit, input int expCycles,
                            output logic [63:0] gotO);
        logic [63:0] gotT;
        logic [63:0] expO;
        logic [63:0] expT;
        logic        prevMdc;
        logic        isRd;
        int          cycles;
        int          nRise;
        int          b;
        isRd = (v.op == 2'b10);
        expO = {32'hFFFF_FFFF, 2'b01, v.op, v.phy, v.regAdr,
                isRd ? 2'b11 : 2'b10, isRd ? 16'hFFFF : v.wdata};
        expT = isRd ? {46'b0, 18'h3FFFF} : 64'b0;
        gotO = '1;
        gotT = '0;
        applyStimulus(v.op, v.phy, v.regAdr, v.wdata);
        checkOutput("entry {busy,ready}", {obsBusy, obsReady}, 2'b10);
        cycles  = 0;
        nRise   = 0;
        prevMdc = obsMdc;
        mdioI   = phyBit(firstBit, v.phyData);
        while (!(obsReady || obsValid) && cycles < 1000) begin
            @(posedge clk); #1;
            cycles++;
            if (obsMdc && !prevMdc) begin
                b = firstBit + nRise;
                if (b < 64) begin
                    gotO[63-b] = obsMdioO;
                    gotT[63-b] = obsMdioT;
                end
                nRise++;
                mdioI = phyBit(firstBit + nRise, v.phyData);
            end
            prevMdc = obsMdc;
        end
        mdioI = 1'b1;
        checkOutput("frame length", 64'(cycles), 64'(expCycles));
        checkOutput("mdc rises", 64'(nRise), 64'(64 - firstBit));
        checkOutput("mdio_o bits", gotO, expO);
        checkOutput("mdio_t bits", gotT, expT);
        checkOutput("end pads {mdc,t}", {obsMdc, obsMdioT}, 2'b01);
        checkOutput("end {valid,busy,ready}", {obsValid, obsBusy, obsReady},
                    isRd ? 3'b110 : 3'b001);
    endtask

    task automatic finishRead(input logic [15:0] expData);
        rdataReady = 1'b1;
        @(posedge clk); #1;
        rdataReady = 1'b0;
        checkOutput("handshake {valid,busy,ready}", {obsValid, obsBusy, obsReady}, 3'b001);
        checkOutput("rdata kept", obsRdata, expData);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        vec_t        v;
        logic [63:0] bits;
        logic        ok;

        vecs[0] = '{2'b01, 5'd1,  5'd0,  16'h1140, 16'h0000, 16'h0000};
        vecs[1] = '{2'b10, 5'd3,  5'd2,  16'h0000, 16'h0141, 16'h0141};
        vecs[2] = '{2'b01, 5'h1F, 5'h1F, 16'hA5C3, 16'h0000, 16'h0141};
        vecs[3] = '{2'b10, 5'h10, 5'h1D, 16'h0000, 16'hF00F, 16'hF00F};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset {ready,busy,valid,mdc,t,o}",
                    {obsReady, obsBusy, obsValid, obsMdc, obsMdioT, obsMdioO}, 6'b100011);
        checkOutput("reset rdata", obsRdata, 16'h0000);
        useNp = 1'b1;
        checkOutput("reset np {ready,busy,mdc,t}", {obsReady, obsBusy, obsMdc, obsMdioT}, 4'b1001);
        useNp = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            runFrame(vecs[i], 0, 128 * HP, bits);
            checkOutput($sformatf("vec%0d rdata", i), obsRdata, vecs[i].expRdata);
            if (vecs[i].op == 2'b10) finishRead(vecs[i].expRdata);
            @(posedge clk); #1;
        end

        // Response stall with a second command waiting behind it.
        v = '{2'b10, 5'd7, 5'd9, 16'h0000, 16'h1234, 16'h1234};
        runFrame(v, 0, 128 * HP, bits);
        op = 2'b01; phyAdr = 5'd5; regAdr = 5'd1; wdata = 16'h5555; cmdValid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!(obsValid && obsRdata == 16'h1234 && !obsReady && obsBusy)) ok = 1'b0;
        end
        checkOutput("stall hold", ok, 1'b1);
        rdataReady = 1'b1;
        @(posedge clk); #1;
        rdataReady = 1'b0;
        checkOutput("stall handshake {valid,busy,ready}", {obsValid, obsBusy, obsReady}, 3'b001);
        @(posedge clk); #1;
        cmdValid = 1'b0;
        checkOutput("queued cmd accepted {busy,ready}", {obsBusy, obsReady}, 2'b10);

        // Reset in the middle of bit 40 of that write.
        repeat (161) @(posedge clk);
        #1;
        checkOutput("mid-frame busy", obsBusy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid-frame reset {mdc,t,ready,busy,valid}",
                    {obsMdc, obsMdioT, obsReady, obsBusy, obsValid}, 5'b01100);
        checkOutput("mid-frame reset rdata", obsRdata, 16'h0000);
        v = '{2'b10, 5'd3, 5'd2, 16'h0000, 16'h8001, 16'h8001};
        runFrame(v, 0, 128 * HP, bits);
        checkOutput("read after reset rdata", obsRdata, 16'h8001);
        finishRead(16'h8001);

        // Invalid opcodes are consumed without a frame.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(k == 0 ? 2'b11 : 2'b00, 5'd1, 5'd1, 16'hFFFF);
            checkOutput("invalid op {busy,ready}", {obsBusy, obsReady}, 2'b01);
            ok = 1'b1;
            repeat (20) begin
                @(posedge clk); #1;
                if (obsMdc || !obsMdioT || obsValid || !obsReady) ok = 1'b0;
            end
            checkOutput("invalid op quiet", ok, 1'b1);
        end

        useNp = 1'b1;
        v = '{2'b01, 5'd2, 5'd4, 16'hBEEF, 16'h0000, 16'h0000};
        runFrame(v, 32, 64 * HP, bits);
        checkOutput("np first bits ST", bits[31:30], 2'b01);
        checkOutput("np rdata", obsRdata, 16'h0000);
        useNp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
